data_mem_ctrl: RTL and testbench

Memory-stage access controller sitting between the pipeline MEM stage and the byte-addressed data RAM (`data_ram256x8`). It accepts one load/store request at a time over a valid/ready handshake and checks alignment and range. It drives the RAM's Enable/RW/Address/DataIn/Size pins for a fixed number of cycles, then returns one response with sign- or zero-extended load data.

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/data_mem_ctrl_load_extend.sv | 23 ++
 rtl/data_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and helpers for the data memory controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Request fields latched at handshake; wdata is already masked to size.
    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Number of bytes touched by an access. The illegal encoding reports 4 so
    // the range check stays conservative; it is rejected separately anyway.
    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        case (size)
            SZ_BYTE: bytes_of = 3'd1;
            SZ_HALF: bytes_of = 3'd2;
            default: bytes_of = 3'd4;
        endcase
    endfunction

    // Clear the store data bits above the access size.
    function automatic logic [31:0] mask_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: mask_data = {24'h0, data[7:0]};
            SZ_HALF: mask_data = {16'h0, data[15:0]};
            default: mask_data = data;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// Formats raw RAM read data to the access size with sign or zero extension.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module load_extend
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    // Select the live bytes and fill the upper bits from the sign bit or zero.
    always_comb begin
        o_data = i_raw;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & i_raw[7]}}, i_raw[7:0]};
            SZ_HALF: o_data = {{16{i_signed & i_raw[15]}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage load/store controller: alignment/range check, timed RAM access, one response.
// Latency: legal access responds WAIT_CYCLES+1 cycles after handshake, illegal after 1.
// Backpressure: req_ready is high only in IDLE; one outstanding request, master holds.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_BYTES   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        ram_enable,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [1:0]  ram_size,
    input  logic [31:0] ram_rdata
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    req_t          r_req;
    logic [CW-1:0] r_cnt;
    logic          w_hs;
    logic          w_illegal;
    logic [32:0]   w_last;
    logic [31:0]   w_load_dat;

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign w_hs      = req_valid && req_ready;

    // RAM pins come straight from the latched request flops, so they stay
    // stable for the whole access window.
    assign ram_rw    = r_req.rw;
    assign ram_addr  = r_req.addr;
    assign ram_wdata = r_req.wdata;
    assign ram_size  = r_req.size;

    // Reject bad size, misalignment, and any access whose last byte lies past the RAM.
    always_comb begin
        w_last    = {1'b0, req_addr} + 33'(bytes_of(req_size)) - 33'd1;
        w_illegal = 1'b0;
        if (req_size == SZ_BAD)
            w_illegal = 1'b1;
        if ((req_size == SZ_HALF) && req_addr[0])
            w_illegal = 1'b1;
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
            w_illegal = 1'b1;
        if (w_last >= 33'(MEM_BYTES))
            w_illegal = 1'b1;
    end

    load_extend u_load_extend (
        .i_size   (r_req.size),
        .i_signed (r_req.sgn),
        .i_raw    (ram_rdata),
        .o_data   (w_load_dat)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state decode: illegal requests skip ACCESS entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hs)
                    w_state_nxt = w_illegal ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (r_cnt == '0)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch request, run the wait counter, build the one-cycle response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req      <= '0;
            r_cnt      <= '0;
            ram_enable <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_req <= '{rw:    req_rw,
                                   size:  req_size,
                                   sgn:   req_signed,
                                   addr:  req_addr,
                                   wdata: mask_data(req_size, req_wdata)};
                        if (w_illegal) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            ram_enable <= 1'b1;
                            r_cnt      <= CNT_INIT;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        ram_enable <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= (r_req.rw == RW_READ) ? w_load_dat : 32'h0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl with a behavioural big-endian byte RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_mem_ctrl;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        ram_enable;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [1:0]  ram_size;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.MEM_BYTES(256), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .ram_enable (ram_enable),
        .ram_rw     (ram_rw),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_size   (ram_size),
        .ram_rdata  (ram_rdata)
    );

    // Behavioural RAM: big-endian bytes, preload while tb_init is high.
    logic [7:0] mem [0:255];
    logic       tb_init;
    logic [7:0] ra0, ra1, ra2, ra3;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h80; mem[1] <= 8'h01; mem[2] <= 8'hFF; mem[3] <= 8'h7E;
        end else if (ram_enable && ram_rw) begin
            case (ram_size)
                2'b00: mem[ra0] <= ram_wdata[7:0];
                2'b01: begin mem[ra0] <= ram_wdata[15:8]; mem[ra1] <= ram_wdata[7:0]; end
                default: begin
                    mem[ra0] <= ram_wdata[31:24]; mem[ra1] <= ram_wdata[23:16];
                    mem[ra2] <= ram_wdata[15:8];  mem[ra3] <= ram_wdata[7:0];
                end
            endcase
        end
    end

    // Read port: upper bits of narrow reads carry junk the controller must drop.
    always_comb begin
        ra0 = ram_addr[7:0];
        ra1 = ra0 + 8'd1;
        ra2 = ra0 + 8'd2;
        ra3 = ra0 + 8'd3;
        case (ram_size)
            2'b00:   ram_rdata = {24'hDEADBE, mem[ra0]};
            2'b01:   ram_rdata = {16'hDEAD, mem[ra0], mem[ra1]};
            default: ram_rdata = {mem[ra0], mem[ra1], mem[ra2], mem[ra3]};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vt [16];

    task automatic drive(input logic rw, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_rw = rw; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    endtask

    // One request: handshake, then watch every cycle until the response.
    task automatic run_vec(input vec_t v, input int idx);
        int en_cnt, lat;
        logic [31:0] seen_wd, seen_addr;
        logic [1:0]  seen_sz;
        logic        seen_rw;
        logic [31:0] got_rd;
        logic        got_err;
        en_cnt = 0; lat = -1; seen_wd = 'x; seen_addr = 'x; seen_sz = 'x; seen_rw = 'x;
        got_rd = 'x; got_err = 'x;
        @(negedge clk);
        drive(v.rw, v.size, v.sgn, v.addr, v.wdata);
        req_valid = 1'b1;
        chk($sformatf("v%0d ready", idx), {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (ram_enable) begin
                en_cnt++;
                seen_wd = ram_wdata; seen_addr = ram_addr; seen_sz = ram_size; seen_rw = ram_rw;
            end
            if (resp_valid) begin
                lat = c; got_rd = resp_rdata; got_err = resp_err;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d latency", idx), lat, v.err ? 32'd1 : 32'(W + 1));
        chk($sformatf("v%0d err", idx), {31'h0, got_err}, {31'h0, v.err});
        chk($sformatf("v%0d rdata", idx), got_rd, v.rdata);
        chk($sformatf("v%0d en_cycles", idx), en_cnt, v.err ? 32'd0 : 32'(W));
        if (!v.err) begin
            chk($sformatf("v%0d ram_addr", idx), seen_addr, v.addr);
            chk($sformatf("v%0d ram_rw", idx), {31'h0, seen_rw}, {31'h0, v.rw});
            chk($sformatf("v%0d ram_size", idx), {30'h0, seen_sz}, {30'h0, v.size});
            if (v.rw) chk($sformatf("v%0d ram_wdata", idx), seen_wd, v.exp_wd);
        end
        @(negedge clk);
        chk($sformatf("v%0d pulse_end", idx), {31'h0, resp_valid}, 32'h0);
        chk($sformatf("v%0d rdata_idle", idx), resp_rdata, 32'h0);
        chk($sformatf("v%0d ready_back", idx), {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int hs_cnt, resp_cnt, last_hs, rst_resp;
        logic hs_now;
        logic [31:0] b2b_exp [4];

        //            rw    size   sgn   addr        wdata         err   rdata         exp_wd
        vt[0]  = '{1'b0, 2'b10, 1'b0, 32'd0,   32'h0,        1'b0, 32'h8001FF7E, 32'h0};
        vt[1]  = '{1'b0, 2'b00, 1'b1, 32'd0,   32'h0,        1'b0, 32'hFFFFFF80, 32'h0};
        vt[2]  = '{1'b0, 2'b00, 1'b0, 32'd0,   32'h0,        1'b0, 32'h00000080, 32'h0};
        vt[3]  = '{1'b0, 2'b01, 1'b0, 32'd2,   32'h0,        1'b0, 32'h0000FF7E, 32'h0};
        vt[4]  = '{1'b0, 2'b01, 1'b1, 32'd2,   32'h0,        1'b0, 32'hFFFFFF7E, 32'h0};
        vt[5]  = '{1'b1, 2'b00, 1'b0, 32'd0,   32'h123456AA, 1'b0, 32'h0,        32'h000000AA};
        vt[6]  = '{1'b0, 2'b10, 1'b0, 32'd0,   32'h0,        1'b0, 32'hAA01FF7E, 32'h0};
        vt[7]  = '{1'b0, 2'b01, 1'b0, 32'd1,   32'h0,        1'b1, 32'h0,        32'h0};
        vt[8]  = '{1'b1, 2'b10, 1'b0, 32'd6,   32'hCAFEF00D, 1'b1, 32'h0,        32'h0};
        vt[9]  = '{1'b0, 2'b11, 1'b0, 32'd0,   32'h0,        1'b1, 32'h0,        32'h0};
        vt[10] = '{1'b0, 2'b10, 1'b0, 32'd254, 32'h0,        1'b1, 32'h0,        32'h0};
        vt[11] = '{1'b1, 2'b01, 1'b0, 32'd254, 32'hFFFF8001, 1'b0, 32'h0,        32'h00008001};
        vt[12] = '{1'b0, 2'b10, 1'b1, 32'd252, 32'h0,        1'b0, 32'h00008001, 32'h0};
        vt[13] = '{1'b0, 2'b00, 1'b1, 32'd255, 32'h0,        1'b0, 32'h00000001, 32'h0};
        vt[14] = '{1'b0, 2'b00, 1'b0, 32'd256, 32'h0,        1'b1, 32'h0,        32'h0};
        vt[15] = '{1'b0, 2'b01, 1'b1, 32'd254, 32'h0,        1'b0, 32'hFFFF8001, 32'h0};

        b2b_exp[0] = 32'h000000AA; b2b_exp[1] = 32'h00000001;
        b2b_exp[2] = 32'h000000FF; b2b_exp[3] = 32'h0000007E;

        tb_init = 1'b1;
        reset_n = 1'b0;
        req_valid = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst ready", {31'h0, req_ready}, 32'h1);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst ram_enable", {31'h0, ram_enable}, 32'h0);
        chk("rst ram_rw", {31'h0, ram_rw}, 32'h0);
        chk("rst ram_addr", ram_addr, 32'h0);
        chk("rst ram_wdata", ram_wdata, 32'h0);
        chk("rst ram_size", {30'h0, ram_size}, 32'h0);

        reset_n = 1'b1;
        tb_init = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(vt[i], i);

        // Back-to-back: req_valid held high across four byte loads of bytes 0..3.
        hs_cnt = 0; resp_cnt = 0; last_hs = -1; hs_now = 1'b0;
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 32'd0, 32'h0);
        req_valid = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (resp_valid) begin
                if (resp_cnt < 4)
                    chk($sformatf("b2b rdata%0d", resp_cnt), resp_rdata, b2b_exp[resp_cnt]);
                resp_cnt++;
            end
            hs_now = req_valid && req_ready;
            if (hs_now) begin
                if (last_hs >= 0)
                    chk($sformatf("b2b gap%0d", hs_cnt), cyc - last_hs, 32'(W + 2));
                last_hs = cyc;
                hs_cnt++;
            end
            if ((resp_cnt == 4) && (hs_cnt == 4)) break;
            @(negedge clk);
            if (hs_now) begin
                if (hs_cnt < 4) req_addr = 32'(hs_cnt);
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("b2b handshakes", hs_cnt, 32'd4);
        chk("b2b responses", resp_cnt, 32'd4);

        // Reset during the second ACCESS cycle of a word store.
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'd8, 32'h11223344);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid en_c1", {31'h0, ram_enable}, 32'h1);
        @(negedge clk);
        chk("rstmid en_c2", {31'h0, ram_enable}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rstmid en_clear", {31'h0, ram_enable}, 32'h0);
        chk("rstmid busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rst_resp = 0;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid) rst_resp++;
            @(negedge clk);
        end
        chk("rstmid no_resp", rst_resp, 32'd0);
        chk("rstmid ready", {31'h0, req_ready}, 32'h1);
        chk("rstmid en_off", {31'h0, ram_enable}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
